// File: rtl/la_pkg.sv
// ---------------------------------------------------------------------------
// la_pkg : shared types and helpers for the logic-analyzer mux controller
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package la_pkg;

    typedef enum logic {
        LA_ACTIVE = 1'b0,
        LA_BLANK  = 1'b1
    } la_state_t;

    localparam int LA_CNT_W = 16;

    function automatic logic [LA_CNT_W-1:0] sat_inc(input logic [LA_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/la_mux_core.sv
// ---------------------------------------------------------------------------
// la_mux_core : combinational (NUM_TEAMS+1):1 selector over a flat LA bus
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module la_mux_core #(
    parameter int  NUM_TEAMS = 12,
    parameter int  LA_WIDTH  = 128,
    localparam int SEL_W     = $clog2(NUM_TEAMS + 1)
) (
    input  logic [LA_WIDTH*(NUM_TEAMS+1)-1:0] flat_in,
    input  logic [SEL_W-1:0]                  sel,
    output logic [LA_WIDTH-1:0]               data_out
);

    logic [LA_WIDTH-1:0] w_slots [NUM_TEAMS+1];

    generate
        for (genvar gi = 0; gi <= NUM_TEAMS; gi++) begin : g_slot
            assign w_slots[gi] = flat_in[gi*LA_WIDTH +: LA_WIDTH];
        end
    endgenerate

    // Compare-and-pick keeps unused select codes from indexing past the array
    always_comb begin
        data_out = '0;
        for (int i = 0; i <= NUM_TEAMS; i++) begin
            if (sel == SEL_W'(i)) begin
                data_out = w_slots[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/la_mux_ctrl.sv
// ---------------------------------------------------------------------------
// la_mux_ctrl : registered LA bus mux with blanked, handshake-guarded switching
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module la_mux_ctrl
    import la_pkg::*;
#(
    parameter int  NUM_TEAMS    = 12,
    parameter int  LA_WIDTH     = 128,
    parameter int  BLANK_CYCLES = 4,
    localparam int SEL_W        = $clog2(NUM_TEAMS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sel_wr,
    input  logic [SEL_W-1:0]                  sel_wdata,
    output logic                              sel_busy,
    input  logic                              err_clr,
    input  logic                              freeze,
    input  logic [LA_WIDTH*(NUM_TEAMS+1)-1:0] designs_la_data_out_flat,
    output logic [LA_WIDTH-1:0]               muxxed_la_dat,
    output logic [SEL_W-1:0]                  active_sel,
    output logic                              sel_err,
    output logic [LA_CNT_W-1:0]               switch_count
);

    localparam int                c_bc_w    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [c_bc_w-1:0] c_bc_load = (BLANK_CYCLES > 0) ? c_bc_w'(BLANK_CYCLES - 1) : '0;

    la_state_t           r_state;
    logic [c_bc_w-1:0]   r_blank_cnt;
    logic [SEL_W-1:0]    r_active_sel;
    logic [SEL_W-1:0]    r_pending;
    logic                r_sel_err;
    logic [LA_CNT_W-1:0] r_switch_count;
    logic [LA_WIDTH-1:0] r_la;

    logic [SEL_W-1:0]    w_mux_sel;
    logic [LA_WIDTH-1:0] w_mux_data;
    logic                w_bad_sel;
    logic                w_err_set;
    logic                w_accept;

    // While blanking, the mux already looks at the pending slot so the exit edge loads it
    assign w_mux_sel = (r_state == LA_BLANK) ? r_pending : r_active_sel;

    la_mux_core #(
        .NUM_TEAMS (NUM_TEAMS),
        .LA_WIDTH  (LA_WIDTH)
    ) u_core (
        .flat_in  (designs_la_data_out_flat),
        .sel      (w_mux_sel),
        .data_out (w_mux_data)
    );

    assign w_bad_sel = (sel_wdata > SEL_W'(NUM_TEAMS));
    assign w_err_set = (r_state == LA_ACTIVE) && sel_wr && w_bad_sel;
    assign w_accept  = (r_state == LA_ACTIVE) && sel_wr && !w_bad_sel &&
                       (sel_wdata != r_active_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= LA_ACTIVE;
            r_blank_cnt    <= '0;
            r_active_sel   <= '0;
            r_pending      <= '0;
            r_sel_err      <= 1'b0;
            r_switch_count <= '0;
            r_la           <= '0;
        end else begin
            if (w_err_set) begin
                r_sel_err <= 1'b1;
            end else if (err_clr) begin
                r_sel_err <= 1'b0;
            end

            case (r_state)
                LA_ACTIVE: begin
                    if (w_accept) begin
                        r_pending <= sel_wdata;
                        if (BLANK_CYCLES > 0) begin
                            r_state     <= LA_BLANK;
                            r_blank_cnt <= c_bc_load;
                            r_la        <= '0;
                        end else begin
                            r_active_sel   <= sel_wdata;
                            r_switch_count <= sat_inc(r_switch_count);
                            if (!freeze) begin
                                r_la <= w_mux_data;
                            end
                        end
                    end else if (!freeze) begin
                        r_la <= w_mux_data;
                    end
                end
                LA_BLANK: begin
                    if (r_blank_cnt == '0) begin
                        r_state        <= LA_ACTIVE;
                        r_active_sel   <= r_pending;
                        r_switch_count <= sat_inc(r_switch_count);
                        r_la           <= w_mux_data;
                    end else begin
                        r_blank_cnt <= r_blank_cnt - 1'b1;
                        r_la        <= '0;
                    end
                end
                default: begin
                    r_state <= LA_ACTIVE;
                    r_la    <= '0;
                end
            endcase
        end
    end

    assign sel_busy      = (r_state == LA_BLANK);
    assign muxxed_la_dat = r_la;
    assign active_sel    = r_active_sel;
    assign sel_err       = r_sel_err;
    assign switch_count  = r_switch_count;

endmodule

`default_nettype wire
